// File: rtl/serial_word_rx.sv
`default_nettype none
// ============================================================================
// Module      : serial_word_rx
// Description : Reassembles WIDTH-bit words from a sampled serial bit stream
//               into a 2-entry valid/ready buffer with a sticky overrun flag.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_word_rx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             sync,
  input  logic             serial_in,
  input  logic             bit_valid,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             overrun,
  input  logic             clr_overrun,
  output logic [1:0]       fill
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] mem0_q, mem0_d;
  logic [WIDTH-1:0] mem1_q, mem1_d;
  logic [1:0]       fill_q, fill_d;
  logic             overrun_q, overrun_d;

  logic [WIDTH-1:0] w_base_word;
  logic [CW-1:0]    w_base_cnt;
  logic [WIDTH-1:0] w_shifted;
  logic             w_sample;
  logic             w_push;
  logic             w_pop;
  logic             w_drop;

  // A sync restarts the word, so the bit sampled on the same edge sees an empty word.
  assign w_base_word = sync ? '0 : shreg_q;
  assign w_base_cnt  = sync ? '0 : cnt_q;
  assign w_sample    = bit_valid && (sync || (state_q == ST_COLLECT));

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shifted = {w_base_word[WIDTH-2:0], serial_in};
    end else begin : g_lsb_first
      assign w_shifted = {serial_in, w_base_word[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    w_push  = 1'b0;
    if (sync) begin
      state_d = ST_COLLECT;
      cnt_d   = '0;
      shreg_d = '0;
    end
    if (w_sample) begin
      if (w_base_cnt == CW'(WIDTH - 1)) begin
        w_push  = 1'b1;
        cnt_d   = '0;
        shreg_d = '0;
      end else begin
        cnt_d   = w_base_cnt + CW'(1);
        shreg_d = w_shifted;
      end
    end
  end

  assign w_pop = (fill_q != 2'd0) && data_ready;

  // mem0 is the head; on draining the last entry it keeps its value.
  always_comb begin
    mem0_d = mem0_q;
    mem1_d = mem1_q;
    fill_d = fill_q;
    w_drop = 1'b0;
    case ({w_pop, w_push})
      2'b10: begin
        if (fill_q == 2'd2) mem0_d = mem1_q;
        fill_d = fill_q - 2'd1;
      end
      2'b11: begin
        if (fill_q == 2'd2) begin
          mem0_d = mem1_q;
          mem1_d = w_shifted;
        end else begin
          mem0_d = w_shifted;
        end
      end
      2'b01: begin
        if (fill_q == 2'd0) begin
          mem0_d = w_shifted;
          fill_d = 2'd1;
        end else if (fill_q == 2'd1) begin
          mem1_d = w_shifted;
          fill_d = 2'd2;
        end else begin
          w_drop = 1'b1;
        end
      end
      default: ;
    endcase
    overrun_d = w_drop | (overrun_q & ~clr_overrun);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      mem0_q    <= '0;
      mem1_q    <= '0;
      fill_q    <= 2'd0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      mem0_q    <= mem0_d;
      mem1_q    <= mem1_d;
      fill_q    <= fill_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_out   = mem0_q;
  assign data_valid = (fill_q != 2'd0);
  assign overrun    = overrun_q;
  assign fill       = fill_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_word_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_word_rx
// Description : Directed vector bench for serial_word_rx, MSB- and LSB-first.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_word_rx;

  typedef struct {
    logic       s, b, v, r, c;
    logic [3:0] o_msb, o_lsb;
    logic       val, ovr;
    logic [1:0] fl;
  } vec_t;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       sync = 1'b0, serial_in = 1'b0, bit_valid = 1'b0;
  logic       data_ready = 1'b0, clr_overrun = 1'b0;
  logic [3:0] out_m, out_l;
  logic       val_m, val_l, ovr_m, ovr_l;
  logic [1:0] fill_m, fill_l;

  int   n_checks = 0;
  int   n_err    = 0;
  vec_t vecs[$];

  always #5 CLK = ~CLK;

  serial_word_rx #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .CLK(CLK), .RST_N(RST_N), .sync(sync), .serial_in(serial_in),
    .bit_valid(bit_valid), .data_out(out_m), .data_valid(val_m),
    .data_ready(data_ready), .overrun(ovr_m), .clr_overrun(clr_overrun),
    .fill(fill_m));

  serial_word_rx #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .CLK(CLK), .RST_N(RST_N), .sync(sync), .serial_in(serial_in),
    .bit_valid(bit_valid), .data_out(out_l), .data_valid(val_l),
    .data_ready(data_ready), .overrun(ovr_l), .clr_overrun(clr_overrun),
    .fill(fill_l));

  function automatic void add(input logic s, b, v, r, c,
                              input logic [3:0] om, ol,
                              input logic val, ovr, input logic [1:0] fl);
    vec_t x;
    x.s = s; x.b = b; x.v = v; x.r = r; x.c = c;
    x.o_msb = om; x.o_lsb = ol; x.val = val; x.ovr = ovr; x.fl = fl;
    vecs.push_back(x);
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic check_outputs(input int idx, input logic [3:0] om, input logic [3:0] ol,
                               input logic val, input logic ovr, input logic [1:0] fl);
    chk("data_out_msb", idx, out_m, om);
    chk("data_out_lsb", idx, out_l, ol);
    chk("data_valid_msb", idx, {3'b0, val_m}, {3'b0, val});
    chk("data_valid_lsb", idx, {3'b0, val_l}, {3'b0, val});
    chk("overrun_msb", idx, {3'b0, ovr_m}, {3'b0, ovr});
    chk("overrun_lsb", idx, {3'b0, ovr_l}, {3'b0, ovr});
    chk("fill_msb", idx, {2'b0, fill_m}, {2'b0, fl});
    chk("fill_lsb", idx, {2'b0, fill_l}, {2'b0, fl});
  endtask

  task automatic run_row(input vec_t x, input int idx);
    sync = x.s; serial_in = x.b; bit_valid = x.v;
    data_ready = x.r; clr_overrun = x.c;
    @(posedge CLK);
    #1;
    check_outputs(idx, x.o_msb, x.o_lsb, x.val, x.ovr, x.fl);
  endtask

  localparam logic [3:0] W_B = 4'b1011, W_D = 4'b1101, W_6 = 4'b0110;
  localparam logic [3:0] W_F = 4'b1111, W_C = 4'b1100, W_3 = 4'b0011;

  initial begin
    // basic word: sync + 1,0,1,1
    add(1,1,1,0,0, 4'h0,4'h0,0,0,0);
    add(0,0,1,0,0, 4'h0,4'h0,0,0,0);
    add(0,1,1,0,0, 4'h0,4'h0,0,0,0);
    add(0,1,1,0,0, W_B,W_D,1,0,1);
    add(0,0,0,1,0, W_B,W_D,0,0,0);
    // three words with no sink: 1011, 0110, 1111 (last dropped)
    add(0,1,1,0,0, W_B,W_D,0,0,0);
    add(0,0,1,0,0, W_B,W_D,0,0,0);
    add(0,1,1,0,0, W_B,W_D,0,0,0);
    add(0,1,1,0,0, W_B,W_D,1,0,1);
    add(0,0,1,0,0, W_B,W_D,1,0,1);
    add(0,1,1,0,0, W_B,W_D,1,0,1);
    add(0,1,1,0,0, W_B,W_D,1,0,1);
    add(0,0,1,0,0, W_B,W_D,1,0,2);
    add(0,1,1,0,0, W_B,W_D,1,0,2);
    add(0,1,1,0,0, W_B,W_D,1,0,2);
    add(0,1,1,0,0, W_B,W_D,1,0,2);
    add(0,1,1,0,0, W_B,W_D,1,1,2);
    add(0,0,0,1,0, W_6,W_6,1,1,1);
    add(0,0,0,1,0, W_6,W_6,0,1,0);
    add(0,0,0,0,1, W_6,W_6,0,0,0);
    // full buffer, third word completes together with a pop
    add(0,1,1,0,0, W_6,W_6,0,0,0);
    add(0,0,1,0,0, W_6,W_6,0,0,0);
    add(0,1,1,0,0, W_6,W_6,0,0,0);
    add(0,1,1,0,0, W_B,W_D,1,0,1);
    add(0,0,1,0,0, W_B,W_D,1,0,1);
    add(0,1,1,0,0, W_B,W_D,1,0,1);
    add(0,1,1,0,0, W_B,W_D,1,0,1);
    add(0,0,1,0,0, W_B,W_D,1,0,2);
    add(0,1,1,0,0, W_B,W_D,1,0,2);
    add(0,1,1,0,0, W_B,W_D,1,0,2);
    add(0,1,1,0,0, W_B,W_D,1,0,2);
    add(0,1,1,1,0, W_6,W_6,1,0,2);
    add(0,0,0,1,0, W_F,W_F,1,0,1);
    add(0,0,0,1,0, W_F,W_F,0,0,0);
    // resync discards partial 1,0; word becomes 1,1,0,0
    add(1,1,1,0,0, W_F,W_F,0,0,0);
    add(0,0,1,0,0, W_F,W_F,0,0,0);
    add(1,1,1,0,0, W_F,W_F,0,0,0);
    add(0,1,1,0,0, W_F,W_F,0,0,0);
    add(0,0,1,0,0, W_F,W_F,0,0,0);
    add(0,0,1,0,0, W_C,W_3,1,0,1);
    add(0,0,0,1,0, W_C,W_3,0,0,0);
    add(0,1,0,1,0, W_C,W_3,0,0,0);
    // clear coincident with a drop: set wins
    add(0,1,1,0,0, W_C,W_3,0,0,0);
    add(0,1,1,0,0, W_C,W_3,0,0,0);
    add(0,1,1,0,0, W_C,W_3,0,0,0);
    add(0,1,1,0,0, W_F,W_F,1,0,1);
    add(0,0,1,0,0, W_F,W_F,1,0,1);
    add(0,0,1,0,0, W_F,W_F,1,0,1);
    add(0,0,1,0,0, W_F,W_F,1,0,1);
    add(0,0,1,0,0, W_F,W_F,1,0,2);
    add(0,1,1,0,0, W_F,W_F,1,0,2);
    add(0,1,1,0,0, W_F,W_F,1,0,2);
    add(0,1,1,0,0, W_F,W_F,1,0,2);
    add(0,1,1,0,1, W_F,W_F,1,1,2);
    add(0,0,0,0,1, W_F,W_F,1,0,2);

    repeat (2) @(posedge CLK);
    #1;
    check_outputs(-1, 4'h0, 4'h0, 1'b0, 1'b0, 2'd0);
    #2 RST_N = 1'b1;
    @(posedge CLK);
    #1;

    for (int i = 0; i < vecs.size(); i++) run_row(vecs[i], i);

    // asynchronous reset mid-word with a full buffer and pending overrun source
    begin
      vec_t x;
      x = vecs[0]; x.o_msb = W_F; x.o_lsb = W_F; x.val = 1; x.ovr = 0; x.fl = 2;
      run_row(x, 100);
      x.s = 0; x.b = 0;
      run_row(x, 101);
    end
    sync = 1'b0; bit_valid = 1'b0;
    #2 RST_N = 1'b0;
    #1 check_outputs(200, 4'h0, 4'h0, 1'b0, 1'b0, 2'd0);
    @(posedge CLK);
    #3 RST_N = 1'b1;
    begin
      vec_t x;
      // IDLE ignores bits without sync
      x = vecs[0]; x.s = 0; x.o_msb = 4'h0; x.o_lsb = 4'h0; x.val = 0; x.fl = 0;
      run_row(x, 201);
      run_row(x, 202);
      x.s = 1; x.b = 1; run_row(x, 203);
      x.s = 0; x.b = 0; run_row(x, 204);
      x.b = 1; run_row(x, 205);
      x.b = 0; x.o_msb = 4'b1010; x.o_lsb = 4'b0101; x.val = 1; x.fl = 1;
      run_row(x, 206);
      x.v = 0; x.r = 1; x.val = 0; x.fl = 0;
      run_row(x, 207);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
